// File: rtl/pcss_inf_bridge.sv
//------------------------------------------------------------------------------
// pcss_inf_bridge: 64-bit AXI-Stream <-> 16-bit parity chip link, plus tik strobe
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pcss_inf_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int TIK_PERIOD     = 1000,
  parameter int TIK_HIGH       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_send_tdata,
  input  logic                      S_AXIS_send_tvalid,
  input  logic                      S_AXIS_send_tlast,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_send_tkeep,
  output logic                      S_AXIS_send_tready,
  output logic [DATA_WIDTH-1:0]     M_AXIS_recv_tdata,
  output logic                      M_AXIS_recv_tvalid,
  output logic                      M_AXIS_recv_tlast,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_recv_tkeep,
  input  logic                      M_AXIS_recv_tready,
  output logic                      tik,
  output logic [CHIPDATA_WIDTH-1:0] recv_data_in_E,
  output logic                      recv_data_valid_E,
  output logic                      recv_data_par_E,
  input  logic                      recv_data_ready_E,
  input  logic                      recv_data_err_E,
  input  logic [CHIPDATA_WIDTH-1:0] send_data_out_E,
  input  logic                      send_data_valid_E,
  input  logic                      send_data_par_E,
  output logic                      send_data_ready_E,
  output logic                      send_data_err_E
);

  localparam int c_FLITS = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int c_IDX_W = (c_FLITS > 1) ? $clog2(c_FLITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_FLITS - 1);
  localparam int c_TIK_W = (TIK_PERIOD > 1) ? $clog2(TIK_PERIOD) : 1;
  localparam logic [c_TIK_W-1:0] c_TIK_MAX  = c_TIK_W'(TIK_PERIOD - 1);
  localparam logic [c_TIK_W-1:0] c_TIK_HIGH = c_TIK_W'(TIK_HIGH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // TX path
  tx_state_t                 r_tx_state;
  logic                      r_tx_ready;
  logic                      r_tx_valid;
  logic [CHIPDATA_WIDTH-1:0] r_tx_data;
  logic                      r_tx_par;
  logic [DATA_WIDTH-1:0]     r_tx_word;
  logic [c_IDX_W-1:0]        r_tx_idx;
  logic [CHIPDATA_WIDTH-1:0] w_tx_first;
  logic [CHIPDATA_WIDTH-1:0] w_tx_next;

  // RX path
  logic [DATA_WIDTH-1:0]     r_rx_asm;
  logic [c_IDX_W-1:0]        r_rx_cnt;
  logic [DATA_WIDTH-1:0]     r_m_tdata;
  logic                      r_m_tvalid;
  logic                      r_rx_ready;
  logic                      r_rx_err;
  logic                      w_rx_take;
  logic                      w_rx_good;
  logic                      w_rx_last;
  logic                      w_m_tvalid_nxt;

  // Timestep strobe
  logic [c_TIK_W-1:0]        r_tik_cnt;
  logic                      r_tik;

  logic                      w_unused;

  assign w_unused   = ^{S_AXIS_send_tlast, S_AXIS_send_tkeep};
  assign w_tx_first = S_AXIS_send_tdata[DATA_WIDTH-1 -: CHIPDATA_WIDTH];
  // r_tx_word is shifted left per flit, so the following flit always sits just below the top
  assign w_tx_next  = r_tx_word[DATA_WIDTH-CHIPDATA_WIDTH-1 -: CHIPDATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_par   <= 1'b0;
      r_tx_word  <= '0;
      r_tx_idx   <= '0;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (S_AXIS_send_tvalid && r_tx_ready) begin
            r_tx_word  <= S_AXIS_send_tdata;
            r_tx_idx   <= '0;
            r_tx_data  <= w_tx_first;
            r_tx_par   <= ^w_tx_first;
            r_tx_valid <= 1'b1;
            r_tx_ready <= 1'b0;
            r_tx_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // an err handshake leaves everything untouched so the same flit is re-presented
          if (recv_data_ready_E && !recv_data_err_E) begin
            if (r_tx_idx == c_LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_tx_ready <= 1'b1;
              r_tx_state <= ST_IDLE;
            end else begin
              r_tx_idx  <= r_tx_idx + 1'b1;
              r_tx_word <= r_tx_word << CHIPDATA_WIDTH;
              r_tx_data <= w_tx_next;
              r_tx_par  <= ^w_tx_next;
            end
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rx_take      = send_data_valid_E && r_rx_ready;
    w_rx_good      = ~^{send_data_par_E, send_data_out_E};
    w_rx_last      = w_rx_take && w_rx_good && (r_rx_cnt == c_LAST_IDX);
    w_m_tvalid_nxt = r_m_tvalid;
    if (w_rx_last)
      w_m_tvalid_nxt = 1'b1;
    else if (r_m_tvalid && M_AXIS_recv_tready)
      w_m_tvalid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_asm   <= '0;
      r_rx_cnt   <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_rx_ready <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_m_tvalid <= w_m_tvalid_nxt;
      // ready tracks the next tvalid so a flit can land right after the host handshake
      r_rx_ready <= ~w_m_tvalid_nxt;
      r_rx_err   <= w_rx_take && !w_rx_good;
      if (w_rx_take && w_rx_good) begin
        r_rx_asm <= {r_rx_asm[DATA_WIDTH-CHIPDATA_WIDTH-1:0], send_data_out_E};
        if (w_rx_last) begin
          r_rx_cnt  <= '0;
          r_m_tdata <= {r_rx_asm[DATA_WIDTH-CHIPDATA_WIDTH-1:0], send_data_out_E};
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tik_cnt <= '0;
      r_tik     <= 1'b0;
    end else begin
      r_tik_cnt <= (r_tik_cnt == c_TIK_MAX) ? '0 : r_tik_cnt + 1'b1;
      r_tik     <= (r_tik_cnt < c_TIK_HIGH);
    end
  end

  assign S_AXIS_send_tready = r_tx_ready;
  assign recv_data_in_E     = r_tx_data;
  assign recv_data_valid_E  = r_tx_valid;
  assign recv_data_par_E    = r_tx_par;
  assign M_AXIS_recv_tdata  = r_m_tdata;
  assign M_AXIS_recv_tvalid = r_m_tvalid;
  assign M_AXIS_recv_tlast  = 1'b1;
  assign M_AXIS_recv_tkeep  = '1;
  assign send_data_ready_E  = r_rx_ready;
  assign send_data_err_E    = r_rx_err;
  assign tik                = r_tik;

endmodule

`default_nettype wire

// File: tb/tb_pcss_inf_bridge.sv
//------------------------------------------------------------------------------
// tb_pcss_inf_bridge: directed and random checks of pcss_inf_bridge against a queue model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pcss_inf_bridge;

  localparam int P = 40;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] S_AXIS_send_tdata;
  logic        S_AXIS_send_tvalid;
  logic        S_AXIS_send_tlast;
  logic [7:0]  S_AXIS_send_tkeep;
  logic        S_AXIS_send_tready;
  logic [63:0] M_AXIS_recv_tdata;
  logic        M_AXIS_recv_tvalid;
  logic        M_AXIS_recv_tlast;
  logic [7:0]  M_AXIS_recv_tkeep;
  logic        M_AXIS_recv_tready;
  logic        tik;
  logic [15:0] recv_data_in_E;
  logic        recv_data_valid_E;
  logic        recv_data_par_E;
  logic        recv_data_ready_E;
  logic        recv_data_err_E;
  logic [15:0] send_data_out_E;
  logic        send_data_valid_E;
  logic        send_data_par_E;
  logic        send_data_ready_E;
  logic        send_data_err_E;

  always #5 clk = ~clk;

  pcss_inf_bridge #(
    .DATA_WIDTH(64), .CHIPDATA_WIDTH(16), .TIK_PERIOD(P), .TIK_HIGH(H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_send_tdata(S_AXIS_send_tdata), .S_AXIS_send_tvalid(S_AXIS_send_tvalid),
    .S_AXIS_send_tlast(S_AXIS_send_tlast), .S_AXIS_send_tkeep(S_AXIS_send_tkeep),
    .S_AXIS_send_tready(S_AXIS_send_tready),
    .M_AXIS_recv_tdata(M_AXIS_recv_tdata), .M_AXIS_recv_tvalid(M_AXIS_recv_tvalid),
    .M_AXIS_recv_tlast(M_AXIS_recv_tlast), .M_AXIS_recv_tkeep(M_AXIS_recv_tkeep),
    .M_AXIS_recv_tready(M_AXIS_recv_tready),
    .tik(tik),
    .recv_data_in_E(recv_data_in_E), .recv_data_valid_E(recv_data_valid_E),
    .recv_data_par_E(recv_data_par_E), .recv_data_ready_E(recv_data_ready_E),
    .recv_data_err_E(recv_data_err_E),
    .send_data_out_E(send_data_out_E), .send_data_valid_E(send_data_valid_E),
    .send_data_par_E(send_data_par_E), .send_data_ready_E(send_data_ready_E),
    .send_data_err_E(send_data_err_E)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state: pending TX flits, accepted RX flits, host-side output
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_err;
  logic        m_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    S_AXIS_send_tvalid = 1'b0;
    S_AXIS_send_tdata  = '0;
    S_AXIS_send_tlast  = 1'b0;
    S_AXIS_send_tkeep  = '0;
    M_AXIS_recv_tready = 1'b0;
    recv_data_ready_E  = 1'b0;
    recv_data_err_E    = 1'b0;
    send_data_out_E    = '0;
    send_data_valid_E  = 1'b0;
    send_data_par_E    = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_tready", S_AXIS_send_tready, 1'b1);
    chk("rst_flit_valid", recv_data_valid_E, 1'b0);
    chk("rst_flit", recv_data_in_E, 16'h0);
    chk("rst_flit_par", recv_data_par_E, 1'b0);
    chk("rst_m_tvalid", M_AXIS_recv_tvalid, 1'b0);
    chk("rst_m_tdata", M_AXIS_recv_tdata, 64'h0);
    chk("rst_m_tlast", M_AXIS_recv_tlast, 1'b1);
    chk("rst_m_tkeep", M_AXIS_recv_tkeep, 8'hFF);
    chk("rst_rx_ready", send_data_ready_E, 1'b0);
    chk("rst_rx_err", send_data_err_E, 1'b0);
    chk("rst_tik", tik, 1'b0);
  endtask

  // Compare outputs with the model, advance the model with the inputs now applied, clock once.
  task automatic cycle();
    logic take;
    logic bad;
    chk("tx_tready", S_AXIS_send_tready, txq.size() == 0);
    chk("tx_valid", recv_data_valid_E, txq.size() != 0);
    if (txq.size() != 0) begin
      chk("tx_flit", recv_data_in_E, txq[0]);
      chk("tx_par", recv_data_par_E, ^txq[0]);
    end
    chk("rx_ready", send_data_ready_E, m_ready);
    chk("rx_err", send_data_err_E, m_err);
    chk("rx_tvalid", M_AXIS_recv_tvalid, m_valid);
    if (m_valid) chk("rx_tdata", M_AXIS_recv_tdata, m_data);

    if (txq.size() == 0 && S_AXIS_send_tvalid) begin
      for (int k = 0; k < 4; k++) txq.push_back(S_AXIS_send_tdata[63-16*k -: 16]);
    end else if (txq.size() != 0 && recv_data_ready_E && !recv_data_err_E) begin
      void'(txq.pop_front());
    end

    take = send_data_valid_E && m_ready;
    bad  = take && (send_data_par_E != ^send_data_out_E);
    if (m_valid && M_AXIS_recv_tready) m_valid = 1'b0;
    if (take && !bad) begin
      rxq.push_back(send_data_out_E);
      if (rxq.size() == 4) begin
        m_data  = {rxq[0], rxq[1], rxq[2], rxq[3]};
        m_valid = 1'b1;
        rxq.delete();
      end
    end
    m_err   = bad;
    m_ready = !m_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [15:0] d, input logic good);
    send_data_valid_E = 1'b1;
    send_data_out_E   = d;
    send_data_par_E   = (^d) ^ !good;
    cycle();
    send_data_valid_E = 1'b0;
  endtask

  initial begin
    logic [15:0] seen[$];
    logic [15:0] exp_flits[4];
    int          low;
    int          falls;
    int          width;
    logic        prev;

    exp_flits[0] = 16'h0123;
    exp_flits[1] = 16'h4567;
    exp_flits[2] = 16'h89AB;
    exp_flits[3] = 16'hCDEF;

    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // tik: high for the first H cycles of every P-cycle period, starting at the first edge
    falls = 0;
    width = 0;
    prev  = 1'b0;
    for (int i = 1; i <= 4 * P; i++) begin
      @(posedge clk);
      #1;
      chk("tik", tik, ((i - 1) % P) < H);
      if (tik) width++;
      if (prev && !tik) begin
        falls++;
        chk("tik_width", width, H);
        width = 0;
      end
      prev = tik;
    end
    chk("tik_falls", falls, 4);
    m_ready = 1'b1;

    // TX with chip always ready
    recv_data_ready_E  = 1'b1;
    S_AXIS_send_tdata  = 64'h0123_4567_89AB_CDEF;
    S_AXIS_send_tvalid = 1'b1;
    cycle();
    S_AXIS_send_tvalid = 1'b0;
    low = 0;
    repeat (5) begin
      if (!S_AXIS_send_tready) low++;
      if (recv_data_valid_E) seen.push_back(recv_data_in_E);
      cycle();
    end
    chk("tx_tready_low_cycles", low, 4);
    chk("tx_flit_count", seen.size(), 4);
    for (int k = 0; k < 4; k++) if (k < seen.size()) chk("tx_flit_seq", seen[k], exp_flits[k]);

    // TX with a retransmit request on the second flit
    S_AXIS_send_tvalid = 1'b1;
    cycle();
    S_AXIS_send_tvalid = 1'b0;
    cycle();
    chk("tx_before_err", recv_data_in_E, 16'h4567);
    recv_data_err_E = 1'b1;
    cycle();
    recv_data_err_E = 1'b0;
    chk("tx_retransmit", recv_data_in_E, 16'h4567);
    repeat (4) cycle();
    chk("tx_done_tready", S_AXIS_send_tready, 1'b1);

    // RX with host back-pressure
    M_AXIS_recv_tready = 1'b0;
    send_flit(16'h1111, 1'b1);
    send_flit(16'h2222, 1'b1);
    send_flit(16'h3333, 1'b1);
    send_flit(16'h4444, 1'b1);
    repeat (3) begin
      chk("rx_hold_tdata", M_AXIS_recv_tdata, 64'h1111_2222_3333_4444);
      chk("rx_hold_ready", send_data_ready_E, 1'b0);
      cycle();
    end
    M_AXIS_recv_tready = 1'b1;
    cycle();
    chk("rx_after_accept", M_AXIS_recv_tvalid, 1'b0);
    chk("rx_ready_again", send_data_ready_E, 1'b1);

    // RX bad parity flit is dropped
    send_flit(16'h0001, 1'b0);
    chk("rx_err_pulse", send_data_err_E, 1'b1);
    send_flit(16'hA5A5, 1'b1);
    chk("rx_err_clear", send_data_err_E, 1'b0);
    send_flit(16'h0F0F, 1'b1);
    send_flit(16'h1234, 1'b1);
    M_AXIS_recv_tready = 1'b0;
    send_flit(16'h8001, 1'b1);
    chk("rx_word_after_bad", M_AXIS_recv_tdata, 64'hA5A5_0F0F_1234_8001);
    M_AXIS_recv_tready = 1'b1;
    cycle();

    // reset in the middle of a TX word and an RX assembly
    S_AXIS_send_tdata  = 64'hFEDC_BA98_7654_3210;
    S_AXIS_send_tvalid = 1'b1;
    cycle();
    S_AXIS_send_tvalid = 1'b0;
    send_flit(16'h7777, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    recv_data_ready_E = 1'b1;
    send_flit(16'h000A, 1'b1);
    send_flit(16'h000B, 1'b1);
    send_flit(16'h000C, 1'b1);
    send_flit(16'h000D, 1'b1);
    chk("rx_word_after_reset", M_AXIS_recv_tdata, 64'h000A_000B_000C_000D);

    // randomized traffic on both paths
    repeat (600) begin
      S_AXIS_send_tvalid = 1'($urandom_range(0, 1));
      S_AXIS_send_tdata  = {$urandom(), $urandom()};
      recv_data_ready_E  = ($urandom_range(0, 3) != 0);
      recv_data_err_E    = ($urandom_range(0, 5) == 0);
      send_data_valid_E  = 1'($urandom_range(0, 1));
      send_data_out_E    = 16'($urandom());
      send_data_par_E    = (^send_data_out_E) ^ ($urandom_range(0, 7) == 0);
      M_AXIS_recv_tready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
